// File: rtl/sobel_window_sequencer.sv
// Host-side sequencer for a 3x3 Sobel core: buffers two lines of a raster
// pixel stream, forms each interior window, launches the core through its
// start/done handshake and streams the returned edge samples out.
module sobel_window_sequencer #(
  parameter int unsigned IMG_ROWS = 436,
  parameter int unsigned IMG_COLS = 576,
  parameter int unsigned PIX_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic [PIX_W-1:0] core_x_1,
  output logic [PIX_W-1:0] core_x_2,
  output logic [PIX_W-1:0] core_x_3,
  output logic [PIX_W-1:0] core_x_4,
  output logic [PIX_W-1:0] core_x_5,
  output logic [PIX_W-1:0] core_x_6,
  output logic [PIX_W-1:0] core_x_7,
  output logic [PIX_W-1:0] core_x_8,
  output logic             core_start,
  input  logic             core_done,
  input  logic [PIX_W-1:0] core_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_last
);

  localparam int unsigned CW = $clog2(IMG_COLS);
  localparam int unsigned RW = $clog2(IMG_ROWS);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_EMIT   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             done_q;
  logic             in_ready_q, in_ready_d;
  logic             core_start_q, core_start_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_eol_q, out_eol_d;
  logic             out_last_q, out_last_d;
  logic             win_eol_q, win_eol_d;
  logic             win_last_q, win_last_d;
  logic [PIX_W-1:0] cx_q [8];
  logic [PIX_W-1:0] cx_d [8];

  // Line buffers (rows r-1 and r-2) and the two older window columns.
  logic [PIX_W-1:0] lb1_q [IMG_COLS];
  logic [PIX_W-1:0] lb2_q [IMG_COLS];
  logic [PIX_W-1:0] t1_q, t2_q, m1_q, m2_q, b1_q, b2_q;

  logic [PIX_W-1:0] rd1, rd2;
  logic             accept, win_fire, done_edge, last_col, last_row;

  assign rd1       = lb1_q[col_q];
  assign rd2       = lb2_q[col_q];
  assign accept    = in_valid && in_ready_q;
  assign last_col  = (col_q == CW'(IMG_COLS - 1));
  assign last_row  = (row_q == RW'(IMG_ROWS - 1));
  assign win_fire  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign done_edge = core_done && !done_q;

  // Raster position counters; advance only on an accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Next-state and registered-output logic of the launch/wait/emit sequencer.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    core_start_d = core_start_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_eol_d    = out_eol_q;
    out_last_d   = out_last_q;
    win_eol_d    = win_eol_q;
    win_last_d   = win_last_q;
    cx_d         = cx_q;
    case (state_q)
      ST_ACCEPT: begin
        in_ready_d = 1'b1;
        if (win_fire) begin
          state_d      = ST_LAUNCH;
          in_ready_d   = 1'b0;
          core_start_d = 1'b0;
          cx_d[0]      = t2_q;
          cx_d[1]      = t1_q;
          cx_d[2]      = rd2;
          cx_d[3]      = m2_q;
          cx_d[4]      = rd1;
          cx_d[5]      = b2_q;
          cx_d[6]      = b1_q;
          cx_d[7]      = in_data;
          win_eol_d    = last_col;
          win_last_d   = last_col && last_row;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_edge) begin
          state_d      = ST_EMIT;
          core_start_d = 1'b1;
          out_valid_d  = 1'b1;
          out_data_d   = core_z;
          out_eol_d    = win_eol_q;
          out_last_d   = win_last_q;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d     = ST_ACCEPT;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ACCEPT;
      col_q        <= '0;
      row_q        <= '0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
      win_eol_q    <= 1'b0;
      win_last_q   <= 1'b0;
      for (int i = 0; i < 8; i++) cx_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      done_q       <= core_done;
      in_ready_q   <= in_ready_d;
      core_start_q <= core_start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_eol_q    <= out_eol_d;
      out_last_q   <= out_last_d;
      win_eol_q    <= win_eol_d;
      win_last_q   <= win_last_d;
      cx_q         <= cx_d;
    end
  end

  // Line buffer rotation and window shift on every accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= in_data;
      lb2_q[col_q] <= rd1;
      t2_q         <= t1_q;
      t1_q         <= rd2;
      m2_q         <= m1_q;
      m1_q         <= rd1;
      b2_q         <= b1_q;
      b1_q         <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign core_start = core_start_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_eol    = out_eol_q;
  assign out_last   = out_last_q;
  assign core_x_1   = cx_q[0];
  assign core_x_2   = cx_q[1];
  assign core_x_3   = cx_q[2];
  assign core_x_4   = cx_q[3];
  assign core_x_5   = cx_q[4];
  assign core_x_6   = cx_q[5];
  assign core_x_7   = cx_q[6];
  assign core_x_8   = cx_q[7];

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Bench for sobel_window_sequencer: a 3x3 and a 4x5 instance, each with a
// delayed-done core stub (z = x_1 ^ x_8) and window/output scoreboards.
module tb_sobel_window_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       vld   [2];
  logic       rdy   [2];
  logic [7:0] dat   [2];
  logic [7:0] cx    [2][8];
  logic       start [2];
  logic       done  [2];
  logic [7:0] z     [2];
  logic       ov    [2];
  logic       ordy  [2];
  logic [7:0] od    [2];
  logic       oe    [2];
  logic       ol    [2];

  int         nstub [2];
  int         hold  [2];
  int         tmr   [2];
  int         hcnt  [2];
  logic       arm   [2];
  logic       stp   [2];
  logic       stray [2];

  logic [7:0] pm [2][4][5];
  int         tr [2];
  int         tc [2];
  int         nr [2] = '{3, 4};
  int         nc [2] = '{3, 5};
  logic [63:0] qw [2][$];
  logic [9:0]  qo [2][$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int drise  [2];
  logic sp   [2];
  logic dp   [2];

  sobel_window_sequencer #(.IMG_ROWS(3), .IMG_COLS(3), .PIX_W(8)) u_dut3 (
    .clk(clk), .reset(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .core_x_1(cx[0][0]), .core_x_2(cx[0][1]), .core_x_3(cx[0][2]), .core_x_4(cx[0][3]),
    .core_x_5(cx[0][4]), .core_x_6(cx[0][5]), .core_x_7(cx[0][6]), .core_x_8(cx[0][7]),
    .core_start(start[0]), .core_done(done[0]), .core_z(z[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_eol(oe[0]), .out_last(ol[0])
  );

  sobel_window_sequencer #(.IMG_ROWS(4), .IMG_COLS(5), .PIX_W(8)) u_dut45 (
    .clk(clk), .reset(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .core_x_1(cx[1][0]), .core_x_2(cx[1][1]), .core_x_3(cx[1][2]), .core_x_4(cx[1][3]),
    .core_x_5(cx[1][4]), .core_x_6(cx[1][5]), .core_x_7(cx[1][6]), .core_x_8(cx[1][7]),
    .core_start(start[1]), .core_done(done[1]), .core_z(z[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_eol(oe[1]), .out_last(ol[1])
  );

  // Core stubs: done rises nstub cycles after start falls, stays high hold cycles.
  assign done[0] = (hcnt[0] != 0) || stray[0];
  assign done[1] = (hcnt[1] != 0) || stray[1];
  assign z[0]    = cx[0][0] ^ cx[0][7];
  assign z[1]    = cx[1][0] ^ cx[1][7];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      stp[k] <= start[k];
      if (stp[k] && !start[k]) begin
        arm[k] <= 1'b1;
        tmr[k] <= nstub[k];
      end else if (start[k]) begin
        arm[k] <= 1'b0;
      end else if (arm[k]) begin
        if (tmr[k] > 1) tmr[k] <= tmr[k] - 1;
        else arm[k] <= 1'b0;
      end
      if (arm[k] && !start[k] && !stp[k] && tmr[k] <= 1) hcnt[k] <= hold[k];
      else if (hcnt[k] > 0) hcnt[k] <= hcnt[k] - 1;
    end
  end

  // Monitors: window at launch, done->start release timing, output scoreboard.
  always @(negedge clk) begin
    logic [63:0] ew;
    logic [9:0]  eo;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst[k]) begin
        if (done[k] && !dp[k]) drise[k] = cyc;
        if (sp[k] && !start[k]) begin
          checks++;
          assert (qw[k].size() != 0) else begin
            errors++;
            $error("FAIL win_unexpected inst=%0d got=launch want=none", k);
          end
          if (qw[k].size() != 0) begin
            ew = qw[k].pop_front();
            checks++;
            assert ({cx[k][0], cx[k][1], cx[k][2], cx[k][3], cx[k][4], cx[k][5], cx[k][6], cx[k][7]} === ew) else begin
              errors++;
              $error("FAIL window inst=%0d got=%h want=%h", k,
                     {cx[k][0], cx[k][1], cx[k][2], cx[k][3], cx[k][4], cx[k][5], cx[k][6], cx[k][7]}, ew);
            end
          end
        end
        if (!sp[k] && start[k]) begin
          checks++;
          assert (cyc - drise[k] == 1) else begin
            errors++;
            $error("FAIL start_release inst=%0d got=%0d want=1", k, cyc - drise[k]);
          end
        end
        if (ov[k] && ordy[k]) begin
          checks++;
          assert (qo[k].size() != 0) else begin
            errors++;
            $error("FAIL out_unexpected inst=%0d got=%h want=none", k, {od[k], oe[k], ol[k]});
          end
          if (qo[k].size() != 0) begin
            eo = qo[k].pop_front();
            checks++;
            assert ({od[k], oe[k], ol[k]} === eo) else begin
              errors++;
              $error("FAIL out inst=%0d got=%h want=%h", k, {od[k], oe[k], ol[k]}, eo);
            end
          end
        end
      end
      sp[k] = start[k];
      dp[k] = done[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one pixel; model its window and result before the DUT accepts it.
  task automatic send(input int k, input logic [7:0] d);
    int r;
    int c;
    int t;
    logic e;
    logic l;
    r = tr[k];
    c = tc[k];
    pm[k][r][c] = d;
    if (r >= 2 && c >= 2) begin
      e = (c == nc[k] - 1);
      l = e && (r == nr[k] - 1);
      qw[k].push_back({pm[k][r-2][c-2], pm[k][r-2][c-1], pm[k][r-2][c], pm[k][r-1][c-2],
                       pm[k][r-1][c], pm[k][r][c-2], pm[k][r][c-1], d});
      qo[k].push_back({pm[k][r-2][c-2] ^ d, e, l});
    end
    tc[k] = c + 1;
    if (tc[k] == nc[k]) begin
      tc[k] = 0;
      tr[k] = (r + 1 == nr[k]) ? 0 : r + 1;
    end
    vld[k] = 1'b1;
    dat[k] = d;
    t = 0;
    while (rdy[k] !== 1'b1 && t < 4000) begin
      tick();
      t++;
    end
    chk("send_accept", 64'(t < 4000), 64'(1));
    tick();
    vld[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (qo[k].size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    chk("drain", 64'(qo[k].size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; vld[k] = 1'b0; dat[k] = '0; ordy[k] = 1'b1;
      nstub[k] = 4; hold[k] = 1; stray[k] = 1'b0;
      tr[k] = 0; tc[k] = 0; sp[k] = 1'b1; dp[k] = 1'b0; drise[k] = 0;
      tmr[k] = 0; hcnt[k] = 0; arm[k] = 1'b0; stp[k] = 1'b1;
    end
    repeat (3) tick();

    // Reset values.
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", 64'(rdy[k]), 64'(0));
      chk("rst_core_start", 64'(start[k]), 64'(1));
      chk("rst_out", 64'({ov[k], od[k], oe[k], ol[k]}), 64'(0));
      chk("rst_core_x", {cx[k][0], cx[k][1], cx[k][2], cx[k][3], cx[k][4], cx[k][5], cx[k][6], cx[k][7]}, 64'(0));
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("ready_low_at_release", 64'(rdy[0]), 64'(0));
    tick();
    chk("ready_first_cycle0", 64'(rdy[0]), 64'(1));
    chk("ready_first_cycle1", 64'(rdy[1]), 64'(1));

    // 3x3 frame 01..09: single result 08, eol and last.
    for (int i = 1; i <= 9; i++) send(0, 8'(i));
    drain(0);

    // Stray done edge while idle must not produce anything.
    stray[1] = 1'b1;
    tick();
    tick();
    stray[1] = 1'b0;
    repeat (5) tick();
    chk("stray_no_out", 64'(ov[1]), 64'(0));
    chk("stray_no_start", 64'(start[1]), 64'(1));

    // Two back-to-back 4x5 ramp frames; stall the first result of frame two.
    for (int i = 0; i < 20; i++) send(1, 8'(i));
    for (int i = 0; i < 20; i++) begin
      if (i == 12) ordy[1] = 1'b0;
      send(1, 8'(i));
      if (i == 12) begin
        t = 0;
        while (ov[1] !== 1'b1 && t < 200) begin
          tick();
          t++;
        end
        chk("stall_reach_emit", 64'(ov[1]), 64'(1));
        for (int s = 0; s < 20; s++) begin
          chk("stall_hold", 64'({od[1], oe[1], ol[1]}), 64'(qo[1][0]));
          chk("stall_ready", 64'(rdy[1]), 64'(0));
          chk("stall_start", 64'(start[1]), 64'(1));
          tick();
        end
        ordy[1] = 1'b1;
      end
    end
    drain(1);

    // Slow core with done held high: one output per window.
    nstub[0] = 512;
    hold[0]  = 5;
    for (int i = 0; i < 9; i++) send(0, 8'(8'h20 + 8'(i * 7)));
    drain(0);
    repeat (20) tick();
    chk("hold_no_extra", 64'(ov[0]), 64'(0));

    // Reset during WAIT_DONE discards the in-flight result.
    hold[0] = 1;
    for (int i = 0; i < 9; i++) send(0, 8'(8'hA0 + 8'(i)));
    repeat (10) tick();
    chk("inflight_start_low", 64'(start[0]), 64'(0));
    rst[0] = 1'b1;
    tick();
    chk("mid_rst_start", 64'(start[0]), 64'(1));
    chk("mid_rst_valid", 64'(ov[0]), 64'(0));
    chk("mid_rst_ready", 64'(rdy[0]), 64'(0));
    tick();
    rst[0] = 1'b0;
    qo[0].delete();
    qw[0].delete();
    tr[0] = 0;
    tc[0] = 0;
    nstub[0] = 4;
    repeat (600) tick();
    chk("mid_rst_no_emit", 64'(ov[0]), 64'(0));
    for (int i = 1; i <= 9; i++) send(0, 8'(i));
    drain(0);

    repeat (5) tick();
    chk("win_queue0_empty", 64'(qw[0].size()), 64'(0));
    chk("win_queue1_empty", 64'(qw[1].size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
